// File: rtl/sp1_stack_if.sv
// Requester-side and RAM-side signal bundle shared by sp1_stack, sp1_ram wiring and the requester.
interface sp1_stack_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic          ready;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          full;
    logic          empty;
    logic [AW:0]   sp;
    logic [1:0]    err;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport master (
        output push, pop, din,
        input  ready, dout, dout_vld, full, empty, sp, err
    );

    modport slave (
        input  push, pop, din, ram_dout,
        output ready, dout, dout_vld, full, empty, sp, err,
        output ram_cs, ram_we, ram_adr, ram_din
    );
endinterface

// File: rtl/sp1_stack.sv
// LIFO stack controller over a single-port synchronous-read RAM (sp1_ram, also defined here).
// Define SP1_STACK_ERR_EN to enable the sticky {overflow, underflow} error flags.
module sp1_ram #(
    parameter int AW = 4,
    parameter int DW = 32,
    parameter int DS = 16
) (
    input  logic          clk,
    input  logic          cs_i,
    input  logic          we_i,
    input  logic [AW-1:0] adr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);
    logic [DW-1:0] mem_q [DS];
    logic [DW-1:0] dout_q;

    // Contents are never cleared; stale words sit above sp and cannot be read back.
    always_ff @(posedge clk) begin
        if (cs_i) begin
            if (we_i) mem_q[adr_i] <= din_i;
            else      dout_q <= mem_q[adr_i];
        end
    end

    assign dout_o = dout_q;
endmodule

module sp1_stack #(
    parameter int AW = 4,
    parameter int DW = 32,
    parameter int DS = 16
) (
    input  logic           clk,
    input  logic           rst,
    sp1_stack_if.slave     stk
);
    typedef enum logic {S_IDLE, S_POP_WAIT} state_t;

    localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   SP_FULL = (AW+1)'(DS);
    localparam logic [AW-1:0] ADR_ONE = AW'(1);

    state_t        state_q, state_d;
    logic [AW:0]   sp_q, sp_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          full, empty, ready;

    assign full  = (sp_q == SP_FULL);
    assign empty = (sp_q == '0);
    assign ready = (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;
        stk.ram_cs  = 1'b0;
        stk.ram_we  = 1'b0;
        stk.ram_adr = '0;
        stk.ram_din = stk.din;
        case (state_q)
            S_IDLE: begin
                // Push wins a simultaneous push/pop; the requester keeps pop asserted.
                if (stk.push) begin
                    if (!full) begin
                        stk.ram_cs  = 1'b1;
                        stk.ram_we  = 1'b1;
                        stk.ram_adr = sp_q[AW-1:0];
                        sp_d        = sp_q + SP_ONE;
                    end
                end else if (stk.pop && !empty) begin
                    stk.ram_cs  = 1'b1;
                    stk.ram_adr = sp_q[AW-1:0] - ADR_ONE;
                    sp_d        = sp_q - SP_ONE;
                    state_d     = S_POP_WAIT;
                end
            end
            S_POP_WAIT: begin
                dout_d     = stk.ram_dout;
                dout_vld_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sp_q       <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

`ifdef SP1_STACK_ERR_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (ready && stk.push && full)               err_d[1] = 1'b1;
        if (ready && stk.pop && !stk.push && empty)  err_d[0] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 2'b00;
        else     err_q <= err_d;
    end

    assign stk.err = err_q;
`else
    assign stk.err = 2'b00;
`endif

    assign stk.ready    = ready;
    assign stk.full     = full;
    assign stk.empty    = empty;
    assign stk.sp       = sp_q;
    assign stk.dout     = dout_q;
    assign stk.dout_vld = dout_vld_q;
endmodule
